reg_rename_stage: RTL
=====================

// Module: reg_rename_stage
// PURPOSE
//  Renames architectural MIPS registers (5b) to physical registers (6b) ahead of the instruction queue.
//  Holds the register alias table (RAT) and the free list of physical registers.
//  Produces one renamed instruction per cycle into the IQ write port via a valid/ready handshake.
//  Commit returns superseded physical registers to the free list.
// PARAMETERS
//  ARCH_REGS  32  architectural register count; r0 is never renamed
//  PHYS_REGS  64  physical register count
//  PHYS_W     6   physical tag width, = clog2(PHYS_REGS)
//  FL_DEPTH   32  free-list depth, = PHYS_REGS-ARCH_REGS
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       reset, synchronous, active-low
//  in_valid        in   1       decoded instruction present
//  in_ready        out  1       stage accepts instruction this cycle
//  in_rs/in_rt     in   5 each  source arch regs
//  in_rw           in   5       destination arch reg
//  in_uses_rw      in   1       instruction writes a destination
//  out_valid       out  1       renamed instruction valid to IQ
//  out_ready       in   1       IQ accepts (has a free entry)
//  out_rs_phys     out  6       renamed rs
//  out_rt_phys     out  6       renamed rt
//  out_rw_phys     out  6       newly allocated destination tag
//  out_old_rw_phys out  6       previous mapping of in_rw, freed at commit
//  free_valid      in   1       commit frees a physical register
//  free_phys       in   6       tag being freed
//  flush           in   1       pipeline drained; restore reset mapping
//  free_count      out  6       entries currently in free list (0..FL_DEPTH)
// BEHAVIOUR
//  Reset: RAT[i]=i; free list = tags 32..63 in order, head=0, free_count=32; out_valid=0;
//   all out_*_phys=0; in_ready follows its equation.
//  alloc_needed = in_uses_rw && in_rw!=0.
//  in_ready = (!out_valid || out_ready) && (!alloc_needed || free_count!=0). Comb.; no dependence on in_valid.
//  accept = in_valid && in_ready. Latency 1: registered outputs update on the cycle after accept.
//  On accept: out_rs/rt_phys = RAT[in_rs/in_rt] read BEFORE this instruction's RAT write
//   (so rw==rs yields the old tag). RAT[0] is always 0.
//  If alloc_needed: pop free-list head into out_rw_phys; out_old_rw_phys = RAT[in_rw];
//   RAT[in_rw] <= popped tag. Otherwise out_rw_phys=0 and out_old_rw_phys=0; no pop, no RAT write.
//  Output holds stable while out_valid && !out_ready. out_valid clears when out_ready and no accept.
//  free_valid pushes free_phys at the tail. A tag freed in cycle N is poppable from cycle N+1 only.
//  Simultaneous push and pop: free_count unchanged; head and tail both advance.
//  Pointers wrap modulo FL_DEPTH.
//  Push when free_count==FL_DEPTH or free_phys==0: ignored; the simulation assertion fires.
//  Empty free list with alloc_needed: in_ready=0. No pop and no RAT change until a free arrives.
//  flush (priority over accept and free): RAT, free list and pointers return to the reset state;
//   out_valid=0 next cycle.
//  rst_n low mid-operation: all state returns to the reset values on that edge. In-flight outputs are lost.
// TESTING
//  1. After reset, rename rw=5: out_rw_phys=32, out_old_rw_phys=5, free_count=31.
//     A following rs=5 returns out_rs_phys=32.
//  2. add r5,r5,r5 after test 1: out_rs/rt_phys=32, out_rw_phys=33, out_old_rw_phys=32.
//  3. 32 back-to-back allocs: free_count=0 and in_ready drops. free_valid phys=7 ->
//     in_ready rises the next cycle; the next alloc gets tag 7.
//  4. IQ stall: out_ready=0 for 3 cycles with in_valid=1 -> outputs held, no RAT/free-list change,
//     in_ready=0. Release -> the next instruction is renamed.
//  5. Alloc and free in the same cycle at free_count=10 -> free_count stays 10.
//     rw=0 and uses_rw=0 instructions -> no pop, out_rw_phys=0.
//  6. flush after 5 renames -> RAT identity, free_count=32, out_valid=0.
//     Free when full -> ignored and the assertion fires.

Source files
------------

// File: rtl/reg_rename_stage.sv
// Register rename stage: RAT plus circular free list of physical tags.
// Emits one renamed instruction per cycle to the IQ over a valid/ready handshake.
module reg_rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PHYS_W    = $clog2(PHYS_REGS),
  parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rw,
  input  logic              in_uses_rw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PHYS_W-1:0] out_rs_phys,
  output logic [PHYS_W-1:0] out_rt_phys,
  output logic [PHYS_W-1:0] out_rw_phys,
  output logic [PHYS_W-1:0] out_old_rw_phys,
  input  logic              free_valid,
  input  logic [PHYS_W-1:0] free_phys,
  input  logic              flush,
  output logic [PHYS_W-1:0] free_count
);

  localparam int FL_W = $clog2(FL_DEPTH);
  localparam logic [PHYS_W-1:0] FL_FULL = PHYS_W'(FL_DEPTH);

  logic [PHYS_W-1:0] rat [ARCH_REGS];
  logic [PHYS_W-1:0] fl  [FL_DEPTH];
  logic [FL_W-1:0]   head;
  logic [FL_W-1:0]   tail;

  logic alloc_needed;
  logic accept;
  logic pop;
  logic push;

  always_comb begin
    alloc_needed = in_uses_rw && (in_rw != 5'd0);
    in_ready     = (!out_valid || out_ready) && (!alloc_needed || (free_count != '0));
    accept       = in_valid && in_ready;
    pop          = accept && alloc_needed;
    push         = free_valid && (free_count != FL_FULL) && (free_phys != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PHYS_W'(i);
      for (int i = 0; i < FL_DEPTH; i++)  fl[i]  <= PHYS_W'(ARCH_REGS + i);
      head       <= '0;
      tail       <= '0;
      free_count <= FL_FULL;
      out_valid  <= 1'b0;
      // A flush keeps the stale payload; only a real reset clears it.
      if (!rst_n) begin
        out_rs_phys     <= '0;
        out_rt_phys     <= '0;
        out_rw_phys     <= '0;
        out_old_rw_phys <= '0;
      end
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_rs_phys <= rat[in_rs];
        out_rt_phys <= rat[in_rt];
        if (alloc_needed) begin
          out_rw_phys     <= fl[head];
          out_old_rw_phys <= rat[in_rw];
          rat[in_rw]      <= fl[head];
        end else begin
          out_rw_phys     <= '0;
          out_old_rw_phys <= '0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (push) begin
        fl[tail] <= free_phys;
        tail     <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      free_count <= free_count + PHYS_W'(push) - PHYS_W'(pop);

      if (free_valid)
        assert ((free_count != FL_FULL) && (free_phys != '0))
        else $warning("reg_rename_stage: free of tag %0d rejected (count %0d)", free_phys, free_count);
    end
  end

endmodule
